// File: rtl/mem_arbiter.sv
// Arbitrates the shared byte-serial memory controller between fetch, load and store.
// Fixed priority store > load > inst, with a starvation override for fetch and flush abort.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_ready,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_data,
  output logic        mc_abort,
  input  logic        mc_ready,
  input  logic [31:0] mc_res
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_INST  = 2'd1;
  localparam logic [1:0] OWN_LOAD  = 2'd2;
  localparam logic [1:0] OWN_STORE = 2'd3;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [0:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_valid_q, mc_valid_d;
  logic             mc_wr_q, mc_wr_d;
  logic [31:0]      mc_addr_q, mc_addr_d;
  logic [2:0]       mc_len_q, mc_len_d;
  logic [31:0]      mc_data_q, mc_data_d;
  logic             abort_q, abort_d;

  logic       spec_flush;
  logic       done_ok;
  logic       inst_ok, ld_ok;
  logic [1:0] gnt;

  // Speculative owners are squashed by a flush; a committed store never is.
  assign spec_flush = flush_in && (owner_q == OWN_INST || owner_q == OWN_LOAD);
  assign done_ok    = rdy_in && state_q == S_BUSY && mc_ready && !spec_flush;

  assign inst_ready = done_ok && owner_q == OWN_INST;
  assign ld_ready   = done_ok && owner_q == OWN_LOAD;
  assign st_ready   = done_ok && owner_q == OWN_STORE;
  assign inst_data  = mc_res;
  assign ld_data    = mc_res;

  assign mc_valid = mc_valid_q;
  assign mc_wr    = mc_wr_q;
  assign mc_addr  = mc_addr_q;
  assign mc_len   = mc_len_q;
  assign mc_data  = mc_data_q;
  assign mc_abort = abort_q && rdy_in;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    mc_valid_d = mc_valid_q;
    mc_wr_d    = mc_wr_q;
    mc_addr_d  = mc_addr_q;
    mc_len_d   = mc_len_q;
    mc_data_d  = mc_data_q;
    abort_d    = abort_q;
    inst_ok    = inst_req && !flush_in;
    ld_ok      = ld_req && !flush_in;
    gnt        = OWN_NONE;

    if (rdy_in) begin
      abort_d = 1'b0;
      if (state_q == S_IDLE) begin
        // The abort cycle itself never grants, so the controller sees a clean gap.
        if (!abort_q) begin
          if (inst_ok && cnt_q == LIMIT) gnt = OWN_INST;
          else if (st_req)               gnt = OWN_STORE;
          else if (ld_ok)                gnt = OWN_LOAD;
          else if (inst_ok)              gnt = OWN_INST;
        end

        case (gnt)
          OWN_STORE: begin
            mc_wr_d   = 1'b1;
            mc_addr_d = st_addr;
            mc_len_d  = st_size;
            mc_data_d = st_data;
          end
          OWN_LOAD: begin
            mc_wr_d   = 1'b0;
            mc_addr_d = ld_addr;
            mc_len_d  = ld_size;
            mc_data_d = 32'd0;
          end
          OWN_INST: begin
            mc_wr_d   = 1'b0;
            mc_addr_d = inst_addr;
            mc_len_d  = 3'b010;
            mc_data_d = 32'd0;
          end
          default: ;
        endcase

        if (gnt != OWN_NONE) begin
          state_d    = S_BUSY;
          owner_d    = gnt;
          mc_valid_d = 1'b1;
        end

        if (flush_in || !inst_req || gnt == OWN_INST)
          cnt_d = '0;
        else if (gnt != OWN_NONE && cnt_q < LIMIT)
          cnt_d = cnt_q + 1'b1;
      end else begin
        if (flush_in) cnt_d = '0;
        if (spec_flush || mc_ready) begin
          state_d    = S_IDLE;
          owner_d    = OWN_NONE;
          mc_valid_d = 1'b0;
          abort_d    = spec_flush;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_NONE;
      cnt_q      <= '0;
      mc_valid_q <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= 32'd0;
      mc_len_q   <= 3'd0;
      mc_data_q  <= 32'd0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      mc_valid_q <= mc_valid_d;
      mc_wr_q    <= mc_wr_d;
      mc_addr_q  <= mc_addr_d;
      mc_len_q   <= mc_len_d;
      mc_data_q  <= mc_data_d;
      abort_q    <= abort_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order scoreboard plus ready/abort/reset checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        inst_req, ld_req, st_req;
  logic [31:0] inst_addr, ld_addr, st_addr, st_data;
  logic [2:0]  ld_size, st_size;
  logic        inst_ready, ld_ready, st_ready;
  logic [31:0] inst_data, ld_data;
  logic        mc_valid, mc_wr, mc_abort, mc_ready;
  logic [31:0] mc_addr, mc_data, mc_res;
  logic [2:0]  mc_len;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
  } txn_t;
  txn_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_data(inst_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_ready(ld_ready), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_ready(st_ready),
    .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len), .mc_data(mc_data),
    .mc_abort(mc_abort), .mc_ready(mc_ready), .mc_res(mc_res)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each new mc_valid assertion is one grant; compare it to the next expected transaction.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (mc_valid === 1'b1 && prev_valid !== 1'b1) begin
      chk("grant pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        txn_t t;
        t = exp_q.pop_front();
        chk("grant wr", 32'(mc_wr), 32'(t.wr));
        chk("grant addr", mc_addr, t.addr);
        chk("grant len", 32'(mc_len), 32'(t.len));
        if (t.wr) chk("grant data", mc_data, t.data);
      end
    end
    prev_valid = mc_valid;
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mc_valid === 1'b1) break;
    end
    chk({tag, " valid"}, 32'(mc_valid), 32'd1);
  endtask

  // exp_rdy = {st, ld, inst}; completes the current transaction after dly cycles.
  task automatic serve(input int dly, input logic [31:0] res, input logic [2:0] exp_rdy,
                       input bit hold_ld, input string tag);
    repeat (dly) @(posedge clk);
    #1 mc_ready = 1'b1; mc_res = res;
    @(negedge clk);
    chk({tag, " ready"}, 32'({st_ready, ld_ready, inst_ready}), 32'(exp_rdy));
    if (exp_rdy[1]) chk({tag, " ld_data"}, ld_data, res);
    if (exp_rdy[0]) chk({tag, " inst_data"}, inst_data, res);
    @(posedge clk);
    #1 mc_ready = 1'b0;
    if (exp_rdy[2]) st_req = 1'b0;
    if (exp_rdy[1] && !hold_ld) ld_req = 1'b0;
    if (exp_rdy[0]) inst_req = 1'b0;
    @(negedge clk);
    chk({tag, " gap valid"}, 32'(mc_valid), 32'd0);
    chk({tag, " gap ready"}, 32'({st_ready, ld_ready, inst_ready}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    inst_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    inst_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0;
    ld_size = '0; st_size = '0; mc_ready = 1'b0; mc_res = '0;
    #2;
    chk("reset outs", 32'({mc_valid, mc_wr, mc_abort, inst_ready, ld_ready, st_ready}), 32'd0);
    chk("reset addr", mc_addr, 32'd0);
    chk("reset data", mc_data, 32'd0);
    chk("reset len", 32'(mc_len), 32'd0);
    @(posedge clk); #1 rst_in = 1'b0;
    @(posedge clk); #1;

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'h1000;
    exp_q.push_back('{1'b0, 32'h1000, 3'b010, 32'd0});
    wait_valid("fetch");
    serve(5, 32'hDEADBEEF, 3'b001, 1'b0, "fetch");

    // Priority: all three in one cycle
    @(posedge clk); #1;
    st_req = 1'b1; st_addr = 32'h2000; st_size = 3'b001; st_data = 32'hCAFE0001;
    ld_req = 1'b1; ld_addr = 32'h3000; ld_size = 3'b100;
    inst_req = 1'b1; inst_addr = 32'h4000;
    exp_q.push_back('{1'b1, 32'h2000, 3'b001, 32'hCAFE0001});
    exp_q.push_back('{1'b0, 32'h3000, 3'b100, 32'd0});
    exp_q.push_back('{1'b0, 32'h4000, 3'b010, 32'd0});
    wait_valid("prio st");
    serve(2, 32'h11111111, 3'b100, 1'b0, "prio st");
    wait_valid("prio ld");
    serve(1, 32'h22222222, 3'b010, 1'b0, "prio ld");
    wait_valid("prio inst");
    serve(1, 32'h33333333, 3'b001, 1'b0, "prio inst");

    // Starvation: loads keep coming while fetch waits
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h5000;
    ld_req = 1'b1; ld_addr = 32'h6000; ld_size = 3'b010;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 32'h6000, 3'b010, 32'd0});
    exp_q.push_back('{1'b0, 32'h5000, 3'b010, 32'd0});
    exp_q.push_back('{1'b0, 32'h6000, 3'b010, 32'd0});
    for (int i = 0; i < 4; i++) begin
      wait_valid("starve ld");
      serve(1, 32'hA0 + 32'(i), 3'b010, 1'b1, "starve ld");
    end
    wait_valid("starve inst");
    chk("starve cnt", 32'(dut.cnt_q), 32'd0);
    serve(1, 32'h55555555, 3'b001, 1'b1, "starve inst");
    wait_valid("starve tail");
    serve(1, 32'h66666666, 3'b010, 1'b0, "starve tail");

    // Flush of a load with mc_ready in the same cycle
    @(posedge clk); #1;
    ld_req = 1'b1; ld_addr = 32'h7000; ld_size = 3'b001;
    exp_q.push_back('{1'b0, 32'h7000, 3'b001, 32'd0});
    wait_valid("flush ld");
    @(posedge clk); #1 flush_in = 1'b1; mc_ready = 1'b1; mc_res = 32'h77777777;
    @(negedge clk);
    chk("flush ld ready", 32'(ld_ready), 32'd0);
    chk("flush ld abort0", 32'(mc_abort), 32'd0);
    @(posedge clk); #1 flush_in = 1'b0; mc_ready = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    chk("flush ld abort1", 32'(mc_abort), 32'd1);
    chk("flush ld valid", 32'(mc_valid), 32'd0);
    @(negedge clk);
    chk("flush ld abort2", 32'(mc_abort), 32'd0);

    // Flush of a committed store is ignored
    @(posedge clk); #1;
    st_req = 1'b1; st_addr = 32'h8000; st_size = 3'b100; st_data = 32'h12345678;
    exp_q.push_back('{1'b1, 32'h8000, 3'b100, 32'h12345678});
    wait_valid("flush st");
    @(posedge clk); #1 flush_in = 1'b1;
    @(negedge clk);
    chk("flush st abort0", 32'(mc_abort), 32'd0);
    @(posedge clk); #1 flush_in = 1'b0;
    @(negedge clk);
    chk("flush st abort1", 32'(mc_abort), 32'd0);
    chk("flush st valid", 32'(mc_valid), 32'd1);
    serve(2, 32'h0, 3'b100, 1'b0, "flush st");

    // Stall: rdy_in low with mc_ready high
    @(posedge clk); #1;
    ld_req = 1'b1; ld_addr = 32'h9000; ld_size = 3'b010;
    exp_q.push_back('{1'b0, 32'h9000, 3'b010, 32'd0});
    wait_valid("stall");
    @(posedge clk); #1 rdy_in = 1'b0; mc_ready = 1'b1; mc_res = 32'h99999999;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall ready", 32'(ld_ready), 32'd0);
      chk("stall valid", 32'(mc_valid), 32'd1);
      @(posedge clk); #1;
    end
    rdy_in = 1'b1;
    @(negedge clk);
    chk("stall resume ready", 32'(ld_ready), 32'd1);
    chk("stall resume data", ld_data, 32'h99999999);
    @(posedge clk); #1 mc_ready = 1'b0; ld_req = 1'b0;

    // Asynchronous reset mid-BUSY
    st_req = 1'b1; st_addr = 32'hA000; st_size = 3'b001; st_data = 32'hFFFF0000;
    exp_q.push_back('{1'b1, 32'hA000, 3'b001, 32'hFFFF0000});
    wait_valid("areset");
    #2 rst_in = 1'b1;
    #1;
    chk("areset outs", 32'({mc_valid, mc_wr, mc_abort, inst_ready, ld_ready, st_ready}), 32'd0);
    chk("areset addr", mc_addr, 32'd0);
    chk("areset data", mc_data, 32'd0);
    chk("areset len", 32'(mc_len), 32'd0);
    st_req = 1'b0;
    @(posedge clk); #1 rst_in = 1'b0;
    @(negedge clk);
    chk("post reset valid", 32'(mc_valid), 32'd0);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the shared byte-serial memory controller between three requesters: instruction-fetch miss, load unit and committed-store unit.
- Sits between the instruction cache / LSB and the memory controller.
- Fixed priority store > load > inst, with an anti-starvation counter for instruction fetch.
- Handles pipeline flush: aborts speculative traffic (inst, load); committed stores always complete.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants tolerated while inst_req is pending before inst is forced next.
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  misprediction flush
- inst_req  in  1  fetch request, held until inst_ready
- inst_addr  in  32  fetch address
- inst_ready  out  1  one-cycle completion pulse
- inst_data  out  32  fetched word, valid with inst_ready
- ld_req  in  1  load request, held until ld_ready
- ld_addr  in  32  load address
- ld_size  in  3  load length code, passed through
- ld_ready  out  1  one-cycle pulse
- ld_data  out  32  load result, valid with ld_ready
- st_req  in  1  store request, held until st_ready
- st_addr  in  32  store address
- st_size  in  3  store length code
- st_data  in  32  store value
- st_ready  out  1  one-cycle pulse
- mc_valid  out  1  request to memory controller
- mc_wr  out  1  1 = write
- mc_addr  out  32  controller address
- mc_len  out  3  controller length code
- mc_data  out  32  write data
- mc_abort  out  1  one-cycle abort; resets controller sequencing
- mc_ready  in  1  controller completion
- mc_res  in  32  controller read result

Behaviour:
- Reset (async): state IDLE, owner NONE, starve counter 0; mc_valid, mc_wr, mc_abort, all ready outputs 0; mc_addr, mc_data, mc_len 0.
- rdy_in low: no state, counter or register updates; ready outputs and mc_abort forced 0.
- States: IDLE, BUSY. Owner register in {INST, LOAD, STORE}.
- IDLE arbitration, per cycle with rdy_in=1:
  - If inst_req and counter == STARVE_LIMIT: grant INST.
  - Otherwise grant st_req, else ld_req, else inst_req.
  - On grant: register the request fields (inst uses mc_wr=0, mc_len=3'b010); mc_valid=1 from the next cycle; go BUSY.
- Starve counter:
  - Increments on each STORE/LOAD grant while inst_req=1; saturates at STARVE_LIMIT.
  - Clears on any INST grant, or whenever inst_req=0 in IDLE.
- BUSY, mc_ready=1: pulse the owner's ready output in the same cycle (combinational from mc_ready & owner & rdy_in); data outputs = mc_res. Next cycle: IDLE, mc_valid=0.
- Back-to-back: the earliest new grant is in the first IDLE cycle; mc_valid has a minimum one-cycle gap between transactions.
- Flush (flush_in=1, rdy_in=1):
  - BUSY with owner INST or LOAD: mc_abort pulses 1 in the next cycle; mc_valid=0; go IDLE; no ready pulse, even if mc_ready is high in the same cycle (flush wins).
  - BUSY with owner STORE: ignored; the store completes normally and st_ready pulses.
  - IDLE: inst_req and ld_req ignored this cycle; a pending st_req may still be granted.
  - Starve counter clears.
- mc_abort is never asserted except after a flush of INST/LOAD. After mc_abort, IDLE lasts at least one cycle before the next grant.
- Requesters must not change their fields while their request is pending; the arbiter does not sample them after the grant.

Test Plan:
- Single fetch: inst_req, addr 0x1000, mc_ready after 5 cycles with mc_res 0xDEADBEEF -> mc_valid=1, mc_addr 0x1000, mc_len 2, mc_wr 0; inst_ready one cycle with inst_data 0xDEADBEEF; mc_valid 0 next cycle.
- Priority: st_req, ld_req and inst_req all raised in the same IDLE cycle -> grant order STORE, LOAD, INST, with mc_wr=1 only for the first.
- Starvation: inst_req held while ld_req is reasserted continuously, limit 4 -> 4 load grants, then INST is granted 5th; the counter is 0 afterwards.
- Flush of a load: load BUSY, flush_in with mc_ready in the same cycle -> no ld_ready; mc_abort=1 for exactly one cycle; IDLE.
- Flush of a store: store BUSY, flush_in asserted, then mc_ready 3 cycles later -> no mc_abort; st_ready pulses.
- Stall and reset: rdy_in low for 4 cycles mid-transaction with mc_ready high -> no ready pulse, state held; rst_in pulsed asynchronously mid-BUSY -> all outputs 0 immediately.
